// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Responder end of the CPU data-SRAM interface. It answers the EXE-stage
// requests of a 5-stage core. Read data is registered, so the core sees it in
// MEM, one cycle after it issues the request. There is no backpressure, so one
// request can be accepted on every cycle.
//
// Address map
//   addr[31:16] == MMIO_HI : MMIO window, word offset addr[15:2]
//       0x0000 LED     : RW, only byte lanes 0-1 are writable
//       0x0004 TIMER   : RW, free-running; a write loads the byte-merge instead
//                        of incrementing
//       0x0008 SCRATCH : RW, byte-enabled
//       0x000C ERR_CNT : RO value; any write clears it
//       other          : reads 0, writes are dropped, err_cnt saturates upward
//   otherwise           : word RAM, index addr[DEPTH_LOG2+1:2] (aliases above)
//
// The RAM powers up with unknown contents.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   resetn          : asynchronous active-low reset (RAM contents are kept)
//   data_sram_en    : request valid
//   data_sram_wen   : byte write enables, 0 with en=1 is a read
//   data_sram_addr  : byte address, addr[1:0] ignored
//   data_sram_wdata : write data, lanes aligned to wen
//   data_sram_rdata : registered read data, holds until the next read
//   led             : LED register
//   err_cnt         : saturating count of accesses to undefined MMIO offsets
// -----------------------------------------------------------------------------
module data_sram_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [15:0] MMIO_HI    = 16'hbfaf,
    parameter              INIT_FILE  = "dsram_init.hex"
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic [15:0] err_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem [0:DEPTH-1];

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic                  is_mmio;
    logic                  is_write;
    logic [DEPTH_LOG2-1:0] ram_index;
    logic [13:0]           mmio_word;
    logic                  ram_wr;
    logic                  mmio_wr;
    logic                  mmio_rd;
    logic                  sel_led;
    logic                  sel_timer;
    logic                  sel_scratch;
    logic                  sel_err;
    logic                  sel_undef;

    assign is_mmio     = (data_sram_addr[31:16] == MMIO_HI);
    assign is_write    = |data_sram_wen;
    assign ram_index   = data_sram_addr[DEPTH_LOG2+1:2];
    assign mmio_word   = data_sram_addr[15:2];

    assign ram_wr      = data_sram_en && !is_mmio && is_write;
    assign mmio_wr     = data_sram_en &&  is_mmio && is_write;
    assign mmio_rd     = data_sram_en &&  is_mmio && !is_write;

    assign sel_led     = (mmio_word == 14'd0);
    assign sel_timer   = (mmio_word == 14'd1);
    assign sel_scratch = (mmio_word == 14'd2);
    assign sel_err     = (mmio_word == 14'd3);
    assign sel_undef   = !(sel_led || sel_timer || sel_scratch || sel_err);

    // Address bits [1:0] and the INIT_FILE name are intentionally unused in
    // the default build.
    logic unused_cfg;
    assign unused_cfg = (^data_sram_addr[1:0]) ^ (INIT_FILE != "");

    // Expand the byte enables to a bit mask for the MMIO byte merges.
    logic [31:0] byte_mask;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign byte_mask[8*gi +: 8] = {8{data_sram_wen[gi]}};
        end
    endgenerate

    // ---------------------------------------------------------------------
    // RAM write port: byte-enabled, no reset so it maps onto block RAM.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[ram_index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // MMIO registers
    // ---------------------------------------------------------------------
    logic [31:0] timer;
    logic [31:0] scratch;
    logic [31:0] timer_merged;
    logic [31:0] scratch_merged;
    logic [15:0] led_merged;
    logic [31:0] mmio_rdata;

    assign timer_merged   = (timer   & ~byte_mask) | (data_sram_wdata & byte_mask);
    assign scratch_merged = (scratch & ~byte_mask) | (data_sram_wdata & byte_mask);
    // Only lanes 0-1 exist in the LED register; upper enables are ignored.
    assign led_merged     = (led & ~byte_mask[15:0]) | (data_sram_wdata[15:0] & byte_mask[15:0]);

    always_comb begin
        mmio_rdata = 32'h0;
        if (sel_led) begin
            mmio_rdata = {16'h0, led};
        end else if (sel_timer) begin
            mmio_rdata = timer;
        end else if (sel_scratch) begin
            mmio_rdata = scratch;
        end else if (sel_err) begin
            mmio_rdata = {16'h0, err_cnt};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= 32'h0;
            led             <= 16'h0;
            timer           <= 32'h0;
            scratch         <= 32'h0;
            err_cnt         <= 16'h0;
        end else begin
            // Read data: only reads update it, everything else holds.
            if (data_sram_en && !is_write) begin
                if (is_mmio) begin
                    data_sram_rdata <= mmio_rdata;
                end else begin
                    data_sram_rdata <= mem[ram_index];
                end
            end

            // A timer write replaces that cycle's increment.
            if (mmio_wr && sel_timer) begin
                timer <= timer_merged;
            end else begin
                timer <= timer + 32'd1;
            end

            if (mmio_wr && sel_led) begin
                led <= led_merged;
            end

            if (mmio_wr && sel_scratch) begin
                scratch <= scratch_merged;
            end

            // A clear to ERR_CNT never coincides with an undefined access, so
            // the clear cannot be masked by an increment.
            if (mmio_wr && sel_err) begin
                err_cnt <= 16'h0;
            end else if ((mmio_wr || mmio_rd) && sel_undef && (err_cnt != 16'hffff)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule
